// File: rtl/vred_pkg.sv
// Shared types and lane arithmetic for the vector reduction unit.
// Op and element-width encodings, beat bundle, lane-wise combine helper.
package vred_pkg;

    typedef enum logic [2:0] {
        VRED_SUM  = 3'd0,
        VRED_MAXU = 3'd1,
        VRED_MAX  = 3'd2,
        VRED_MINU = 3'd3,
        VRED_MIN  = 3'd4,
        VRED_AND  = 3'd5,
        VRED_OR   = 3'd6,
        VRED_XOR  = 3'd7
    } vred_op_e;

    typedef enum logic [1:0] {
        SEW_8  = 2'd0,
        SEW_16 = 2'd1,
        SEW_32 = 2'd2,
        SEW_64 = 2'd3
    } vred_sew_e;

    // Per-beat bundle travelling down the pipeline with its data.
    typedef struct packed {
        logic        valid;
        logic        first;
        logic        last;
        vred_op_e    op;
        vred_sew_e   sew;
        logic [63:0] seed;
    } vred_beat_t;

    function automatic int sew_bits(vred_sew_e sew);
        int b;
        unique case (sew)
            SEW_8:  b = 8;
            SEW_16: b = 16;
            SEW_32: b = 32;
            SEW_64: b = 64;
        endcase
        return b;
    endfunction

    function automatic logic [63:0] sew_mask(vred_sew_e sew);
        logic [63:0] m;
        unique case (sew)
            SEW_8:  m = 64'h0000_0000_0000_00FF;
            SEW_16: m = 64'h0000_0000_0000_FFFF;
            SEW_32: m = 64'h0000_0000_FFFF_FFFF;
            SEW_64: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    // Combine two zero-extended elements of the given width.
    // Operands are left-aligned so one comparator serves both
    // signed and unsigned ordering.
    function automatic logic [63:0] vred_elem_op(
        vred_op_e    op,
        int          bits,
        logic [63:0] a,
        logic [63:0] b
    );
        logic [63:0] m;
        logic [63:0] sa;
        logic [63:0] sb;
        logic        ltu;
        logic        lts;
        logic [63:0] r;
        m   = (bits == 64) ? '1 : ((64'd1 << bits) - 64'd1);
        sa  = a << (64 - bits);
        sb  = b << (64 - bits);
        ltu = sa < sb;
        lts = $signed(sa) < $signed(sb);
        r   = '0;
        unique case (op)
            VRED_SUM:  r = (a + b) & m;
            VRED_MAXU: r = ltu ? b : a;
            VRED_MAX:  r = lts ? b : a;
            VRED_MINU: r = ltu ? a : b;
            VRED_MIN:  r = lts ? a : b;
            VRED_AND:  r = a & b;
            VRED_OR:   r = a | b;
            VRED_XOR:  r = a ^ b;
        endcase
        return r;
    endfunction

    // Lane-wise combine of two 64-bit words at SEW granularity.
    function automatic logic [63:0] vred_lane_op(
        vred_op_e    op,
        vred_sew_e   sew,
        logic [63:0] a,
        logic [63:0] b
    );
        logic [63:0] r;
        logic [63:0] t;
        r = '0;
        unique case (sew)
            SEW_8: begin
                for (int i = 0; i < 8; i++) begin
                    t = vred_elem_op(op, 8,
                                     {56'd0, a[i*8 +: 8]},
                                     {56'd0, b[i*8 +: 8]});
                    r[i*8 +: 8] = t[7:0];
                end
            end
            SEW_16: begin
                for (int i = 0; i < 4; i++) begin
                    t = vred_elem_op(op, 16,
                                     {48'd0, a[i*16 +: 16]},
                                     {48'd0, b[i*16 +: 16]});
                    r[i*16 +: 16] = t[15:0];
                end
            end
            SEW_32: begin
                for (int i = 0; i < 2; i++) begin
                    t = vred_elem_op(op, 32,
                                     {32'd0, a[i*32 +: 32]},
                                     {32'd0, b[i*32 +: 32]});
                    r[i*32 +: 32] = t[31:0];
                end
            end
            SEW_64: r = vred_elem_op(op, 64, a, b);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vred_fold_stage.sv
// One registered halving stage: folds the high half of a W-bit word onto the low half.
// Ports: clk, rst (async, active-low), in_beat/in_data -> out_beat/out_data.
module vred_fold_stage
    import vred_pkg::*;
#(
    parameter  int W  = 64,
    localparam int IW = (W > 64) ? W : 64,
    localparam int OW = (W > 128) ? W / 2 : 64
) (
    input  logic            clk,
    input  logic            rst,
    input  vred_beat_t      in_beat,
    input  logic [IW-1:0]   in_data,
    output vred_beat_t      out_beat,
    output logic [OW-1:0]   out_data
);

    logic [OW-1:0] fold_res;
    vred_beat_t    beat_d;
    vred_beat_t    beat_q;
    logic [OW-1:0] data_d;
    logic [OW-1:0] data_q;

    if (W > 64) begin : g_wide
        // Halves are whole 64-bit words; SEW never exceeds W/2 here.
        always_comb begin
            fold_res = '0;
            for (int k = 0; k < W / 128; k++) begin
                fold_res[k*64 +: 64] = vred_lane_op(
                    in_beat.op, in_beat.sew,
                    in_data[k*64 +: 64],
                    in_data[W/2 + k*64 +: 64]);
            end
        end
    end else begin : g_narrow
        logic [63:0] lo;
        logic [63:0] hi;
        // Upper lanes see op(0,0) = 0, so the word stays clean above W/2.
        always_comb begin
            lo = '0;
            hi = '0;
            lo[W/2-1:0] = in_data[W/2-1:0];
            hi[W/2-1:0] = in_data[W-1:W/2];
            if (sew_bits(in_beat.sew) > W / 2) begin
                fold_res = in_data;
            end else begin
                fold_res = vred_lane_op(in_beat.op, in_beat.sew, lo, hi);
            end
        end
    end

    always_comb begin
        beat_d       = beat_q;
        beat_d.valid = 1'b0;
        data_d       = data_q;
        if (in_beat.valid) begin
            beat_d = in_beat;
            data_d = fold_res;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_q <= '0;
            data_q <= '0;
        end else begin
            beat_q <= beat_d;
            data_q <= data_d;
        end
    end

    assign out_beat = beat_q;
    assign out_data = data_q;

endmodule

// File: rtl/vred_unit.sv
// Multi-beat vector reduction (sum/min/max/logic) to one SEW-wide result.
// Ports: clk, rst (async, active-low), in_* beat stream, out_vec/out_valid result strobe.
module vred_unit
    import vred_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int OPSEL_WIDTH = 3,
    parameter int SEW_WIDTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  in_vec0,
    input  logic [63:0]            in_vec1,
    input  logic                   in_valid,
    input  logic                   in_start,
    input  logic                   in_end,
    input  logic [OPSEL_WIDTH-1:0] in_opSel,
    input  logic [SEW_WIDTH-1:0]   in_sew,
    output logic [63:0]            out_vec,
    output logic                   out_valid
);

    localparam int N = $clog2(DATA_WIDTH / 8);

    // Input stage
    logic                  busy_d;
    logic                  busy_q;
    vred_op_e              cfg_op_d;
    vred_op_e              cfg_op_q;
    vred_sew_e             cfg_sew_d;
    vred_sew_e             cfg_sew_q;
    vred_beat_t            s0_beat_d;
    vred_beat_t            s0_beat_q;
    logic [DATA_WIDTH-1:0] s0_data_d;
    logic [DATA_WIDTH-1:0] s0_data_q;
    logic                  take_start;
    logic                  take_cont;

    always_comb begin
        busy_d          = busy_q;
        cfg_op_d        = cfg_op_q;
        cfg_sew_d       = cfg_sew_q;
        s0_beat_d       = s0_beat_q;
        s0_beat_d.valid = 1'b0;
        s0_data_d       = s0_data_q;
        take_start      = in_valid && in_start;
        // Non-start beats only count inside an open reduction.
        take_cont       = in_valid && !in_start && busy_q;
        if (take_start) begin
            cfg_op_d        = vred_op_e'(in_opSel);
            cfg_sew_d       = vred_sew_e'(in_sew);
            busy_d          = !in_end;
            s0_beat_d.valid = 1'b1;
            s0_beat_d.first = 1'b1;
            s0_beat_d.last  = in_end;
            s0_beat_d.op    = cfg_op_d;
            s0_beat_d.sew   = cfg_sew_d;
            s0_beat_d.seed  = in_vec1 & sew_mask(cfg_sew_d);
            s0_data_d       = in_vec0;
        end else if (take_cont) begin
            busy_d          = !in_end;
            s0_beat_d.valid = 1'b1;
            s0_beat_d.first = 1'b0;
            s0_beat_d.last  = in_end;
            s0_beat_d.op    = cfg_op_q;
            s0_beat_d.sew   = cfg_sew_q;
            s0_beat_d.seed  = '0;
            s0_data_d       = in_vec0;
        end
    end

    // Fold tree
    vred_beat_t  stage_beat [N+1];
    vred_beat_t  fold_beat;
    logic [63:0] fold_data;

    assign stage_beat[0] = s0_beat_q;

    for (genvar i = 0; i < N; i++) begin : g_fold
        localparam int W  = DATA_WIDTH >> i;
        localparam int IW = (W > 64) ? W : 64;
        localparam int OW = (W > 128) ? W / 2 : 64;
        logic [IW-1:0] d_in;
        logic [OW-1:0] d_out;
        if (i == 0) begin : g_head
            assign d_in = s0_data_q;
        end else begin : g_link
            assign d_in = g_fold[i-1].d_out;
        end
        vred_fold_stage #(
            .W(W)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .in_beat  (stage_beat[i]),
            .in_data  (d_in),
            .out_beat (stage_beat[i+1]),
            .out_data (d_out)
        );
    end

    assign fold_beat = stage_beat[N];
    assign fold_data = g_fold[N-1].d_out;

    // Accumulator and output
    logic [63:0] acc_d;
    logic [63:0] acc_q;
    logic        acc_last_d;
    logic        acc_last_q;
    logic [63:0] out_vec_d;
    logic [63:0] out_vec_q;
    logic        out_valid_d;
    logic        out_valid_q;

    always_comb begin
        acc_d      = acc_q;
        acc_last_d = fold_beat.valid && fold_beat.last;
        if (fold_beat.valid) begin
            acc_d = vred_lane_op(fold_beat.op, fold_beat.sew,
                                 fold_beat.first ? fold_beat.seed : acc_q,
                                 fold_data)
                    & sew_mask(fold_beat.sew);
        end
        out_valid_d = acc_last_q;
        out_vec_d   = acc_last_q ? acc_q : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q      <= 1'b0;
            cfg_op_q    <= VRED_SUM;
            cfg_sew_q   <= SEW_8;
            s0_beat_q   <= '0;
            s0_data_q   <= '0;
            acc_q       <= '0;
            acc_last_q  <= 1'b0;
            out_vec_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            cfg_op_q    <= cfg_op_d;
            cfg_sew_q   <= cfg_sew_d;
            s0_beat_q   <= s0_beat_d;
            s0_data_q   <= s0_data_d;
            acc_q       <= acc_d;
            acc_last_q  <= acc_last_d;
            out_vec_q   <= out_vec_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_vec   = out_vec_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_vred_unit.sv
// Scoreboard bench for vred_unit at 64- and 128-bit beat widths.
// Reference model reduces element lists directly; monitor pops on out_valid.
module tb_vred_unit;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] vec = '0;
    logic [63:0]  seed = '0;
    logic         valid = 1'b0;
    logic         start = 1'b0;
    logic         last = 1'b0;
    logic [2:0]   op = '0;
    logic [1:0]   sew = '0;
    logic [63:0]  o64;
    logic         ov64;
    logic [63:0]  o128;
    logic         ov128;

    always #5 clk = ~clk;

    vred_unit #(.DATA_WIDTH(64)) u_dut64 (
        .clk(clk), .rst(rst), .in_vec0(vec[63:0]), .in_vec1(seed),
        .in_valid(valid), .in_start(start), .in_end(last),
        .in_opSel(op), .in_sew(sew), .out_vec(o64), .out_valid(ov64)
    );

    vred_unit #(.DATA_WIDTH(128)) u_dut128 (
        .clk(clk), .rst(rst), .in_vec0(vec), .in_vec1(seed),
        .in_valid(valid), .in_start(start), .in_end(last),
        .in_opSel(op), .in_sew(sew), .out_vec(o128), .out_valid(ov128)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] val;
        int          at;
    } exp_t;

    exp_t q [2][$];
    int   n_cmp = 0;
    int   n_bad = 0;

    bit          mbusy = 0;
    int          mop = 0;
    int          mbits = 8;
    logic [63:0] macc [2];

    function automatic logic [63:0] mmask(int bits);
        return (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
    endfunction

    function automatic logic [63:0] ref_op(int o, int bits,
                                           logic [63:0] a, logic [63:0] b);
        logic [63:0] sbit = 64'd1 << (bits - 1);
        bit ult = a < b;
        bit slt = (a ^ sbit) < (b ^ sbit);
        case (o)
            0: return (a + b) & mmask(bits);
            1: return ult ? b : a;
            2: return slt ? b : a;
            3: return ult ? a : b;
            4: return slt ? a : b;
            5: return a & b;
            6: return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [63:0] ref_reduce(int o, int bits, logic [63:0] init,
                                               logic [127:0] v, int width);
        logic [63:0]  r = init;
        logic [127:0] s;
        for (int i = 0; i < width / bits; i++) begin
            s = v >> (i * bits);
            r = ref_op(o, bits, r, s[63:0] & mmask(bits));
        end
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic beat(bit v, bit s, bit e, int o, int sw,
                        logic [127:0] d, logic [63:0] sd);
        @(posedge clk);
        #1;
        valid = v; start = s; last = e;
        op = 3'(o); sew = 2'(sw); vec = d; seed = sd;
        if (v) begin
            if (s) begin
                mbusy = 1;
                mop = o;
                mbits = 8 << sw;
                macc[0] = sd & mmask(mbits);
                macc[1] = sd & mmask(mbits);
            end
            if (mbusy) begin
                macc[0] = ref_reduce(mop, mbits, macc[0], {64'd0, d[63:0]}, 64);
                macc[1] = ref_reduce(mop, mbits, macc[1], d, 128);
                if (e) begin
                    q[0].push_back('{macc[0], cyc + 6});
                    q[1].push_back('{macc[1], cyc + 7});
                    mbusy = 0;
                end
            end
        end
    endtask

    task automatic idle(int n);
        repeat (n) beat(0, 0, 0, 0, 0, '0, '0);
    endtask

    task automatic mon(int k, logic ov, logic [63:0] o);
        exp_t e;
        string tag = (k == 0) ? "dut64" : "dut128";
        if (ov) begin
            if (q[k].size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s unexpected pulse: got %h required none (cycle %0d)",
                         tag, o, cyc);
            end else begin
                e = q[k].pop_front();
                chk({tag, " result"}, o, e.val);
                chk({tag, " latency"}, 64'(cyc), 64'(e.at));
            end
        end else begin
            chk({tag, " idle out_vec"}, o, '0);
            if (q[k].size() > 0 && q[k][0].at < cyc) begin
                e = q[k].pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL %s missing pulse: got none required %h at %0d",
                         tag, e.val, e.at);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon(0, ov64, o64);
            mon(1, ov128, o128);
        end
    end

    task automatic reset_pulse();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rst out_valid64", {63'd0, ov64}, '0);
        chk("rst out_vec64", o64, '0);
        chk("rst out_valid128", {63'd0, ov128}, '0);
        chk("rst out_vec128", o128, '0);
        q[0].delete();
        q[1].delete();
        mbusy = 0;
        valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    logic [127:0] ones = '1;

    initial begin
        #12;
        chk("reset out_valid64", {63'd0, ov64}, '0);
        chk("reset out_vec64", o64, '0);
        chk("reset out_valid128", {63'd0, ov128}, '0);
        chk("reset out_vec128", o128, '0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        idle(2);

        // sum, plain and wrapping
        beat(1, 1, 1, 0, 0, 128'h0807060504030201, 64'h10);
        beat(1, 1, 1, 0, 0, ones, 64'h01);
        idle(3);
        // SEW=32 signed/unsigned max, signed min
        beat(1, 1, 1, 2, 2, 128'hFFFFFFFF00000005, 64'h80000000);
        beat(1, 1, 1, 1, 2, 128'hFFFFFFFF00000005, 64'h80000000);
        beat(1, 1, 1, 4, 2, 128'hFFFFFFFF00000005, 64'h80000000);
        beat(1, 1, 1, 3, 2, 128'hFFFFFFFF00000005, 64'h80000000);
        idle(2);
        // back-to-back different SEW
        beat(1, 1, 1, 6, 3, 128'h1, 64'h2);
        beat(1, 1, 1, 5, 0, ones, 64'h0F);
        idle(3);
        // stray beat, then multi-beat min with a gap
        beat(1, 0, 1, 0, 0, '0, '0);
        beat(1, 1, 0, 4, 1, {8{16'h0010}}, 64'h0100);
        idle(1);
        beat(1, 0, 1, 0, 3, {64'h7FFF7FFF7FFF7FFF, 64'h7FFF7FFF00037FFF}, 64'hDEAD);
        idle(3);
        // 64-bit xor across halves
        beat(1, 1, 1, 7, 3, {64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F}, 64'h0);
        idle(2);
        // abort: open reduction restarted by a new start
        beat(1, 1, 0, 0, 0, ones, 64'h55);
        beat(1, 1, 1, 6, 1, 128'h00F0_000F, 64'h0300);
        idle(10);

        // reset two cycles after a start+end beat
        beat(1, 1, 1, 0, 0, 128'h0807060504030201, 64'h10);
        idle(1);
        reset_pulse();
        idle(12);
        // reset while the result pulse is on the output
        beat(1, 1, 1, 6, 3, 128'h1234, 64'h1);
        idle(5);
        reset_pulse();
        idle(12);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            beat(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
                 int'($urandom % 8), int'($urandom % 4),
                 {$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom});
        end
        idle(12);

        chk("dut64 drained", 64'(q[0].size()), '0);
        chk("dut128 drained", 64'(q[1].size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vred_unit.md
Name: vred_unit

Overview:
- Parametrised successor to the fixed 64-bit sum/min/max reduction pipeline in the vALU.
- Reduces every SEW element of a DATA_WIDTH-bit vector beat, plus a scalar seed, to one SEW-wide result.
- Supports eight ops, including signed and unsigned min/max.
- A reduction spans one or more beats delimited by in_start and in_end. Gaps between beats and back-to-back reductions are allowed.

Parameters:
- DATA_WIDTH, 64, beat width in bits; power of two, 64..512.
- OPSEL_WIDTH, 3, op select width.
- SEW_WIDTH, 2, element-width code: 0=8b, 1=16b, 2=32b, 3=64b.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_vec0  in  DATA_WIDTH  vector beat.
- in_vec1  in  64  scalar seed; low SEW bits used, sampled on the start beat only.
- in_valid  in  1  beat valid; always accepted, no backpressure.
- in_start  in  1  first beat of a reduction; qualified by in_valid.
- in_end  in  1  last beat of a reduction; qualified by in_valid; may coincide with in_start.
- in_opSel  in  OPSEL_WIDTH  op, sampled on the start beat.
- in_sew  in  SEW_WIDTH  element width, sampled on the start beat.
- out_vec  out  64  result, zero-extended above SEW.
- out_valid  out  1  one-cycle result strobe.

Behaviour:
- Op encoding: 0 sum, 1 maxu, 2 max, 3 minu, 4 min, 5 and, 6 or, 7 xor.
- Arithmetic:
  - sum wraps modulo 2^SEW.
  - Signed ops treat elements as two's complement.
- Input stage:
  - A start beat loads opSel, sew and seed into active-config registers and sets busy.
  - Beats inside start..end use the latched opSel/sew. Changes to in_opSel/in_sew on non-start beats are ignored.
  - A beat with in_valid=1 and in_start=0 while busy=0 is dropped.
  - The end beat clears busy. A start beat while busy=1 aborts the open reduction (no output) and begins a new one.
- Each stage carries a valid bit and the beat's config. No stage updates arithmetic state on an invalid slot.
- Fold stages:
  - There are N = log2(DATA_WIDTH/8) registered stages.
  - The stage at width W combines the low and high W/2 halves lane-wise at SEW granularity.
  - If W/2 < SEW bits, the stage passes its input through unchanged.
  - The result sits in the low SEW bits.
- Accumulator stage:
  - On a valid start beat: acc = op(seed, fold).
  - On a valid non-start beat: acc = op(acc, fold).
  - Bits above SEW in acc are held at 0.
- Output stage:
  - When an end beat leaves the accumulator, out_vec = acc and out_valid = 1 for exactly one cycle.
  - Otherwise out_valid = 0 and out_vec = 0.
- Latency: end beat at cycle t gives out_valid at t+N+3 (6 for DATA_WIDTH=64, 7 for 128).
- Throughput: one beat per cycle. Single-beat reductions on consecutive cycles give consecutive out_valid pulses, with no cross-contamination.
- Reset:
  - rst low clears every register immediately, regardless of clk: out_vec=0, out_valid=0, busy=0, all stage valids=0, acc=0.
  - Reset mid-reduction discards all in-flight data. No pulse is emitted after release.
- in_start/in_end/in_opSel/in_sew are don't-care when in_valid=0.

Decomposition:
- Package vred_pkg holds:
  - op encodings (VRED_SUM..VRED_XOR);
  - SEW codes and sew_bits(sew);
  - function vred_lane_op(op, sew, a, b), the 64-bit lane-wise combine used by every fold stage and by the accumulator.
- Sub-module vred_fold_stage, parametrised by W:
  - a registered halving stage with valid and config pass-through;
  - instantiated N times by a generate loop in vred_unit.

Test Plan:
- SEW=8 sum, single beat, vec0=0x0807060504030201, seed=0x10 -> out_vec=0x34 at t+6, out_valid high exactly 1 cycle.
- SEW=8 sum wrap, vec0=0xFFFFFFFFFFFFFFFF, seed=0x01 -> out_vec=0xF9.
- SEW=32, vec0={0xFFFFFFFF,0x00000005}, seed=0x80000000:
  - max -> 0x00000005;
  - maxu -> 0xFFFFFFFF;
  - min -> 0x80000000.
- SEW=16 min, multi-beat with gap and stray beat:
  - stray beat 0x0000000000000000 while idle -> dropped;
  - beat1 all lanes 0x0010 with start;
  - idle cycle;
  - beat2 lanes {0x7FFF,0x0003,0x7FFF,0x7FFF} with end;
  - seed 0x0100;
  - required: out_vec=0x0003 at beat2+6; no pulse after beat1.
- Back-to-back, DATA_WIDTH=64:
  - inputs: cycle0 SEW=64 or, vec0=0x1, seed=0x2; cycle1 SEW=8 and, vec0=0xFF..FF, seed=0x0F;
  - required: out 0x3 then 0x0F on consecutive cycles.
- DATA_WIDTH=128, SEW=64 xor, vec0={0xF0F0F0F0F0F0F0F0,0x0F0F0F0F0F0F0F0F}, seed=0 -> out_vec=0xFFFFFFFFFFFFFFFF at t+7.
- Async reset: rst low between clock edges 2 cycles after a start+end beat -> out_valid=0 and out_vec=0 immediately; no out_valid for 10 cycles after release.
